// File: rtl/seq_booth_divider_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the sequential signed divider that sits beside the
// radix-4 Booth multiplier in the arithmetic unit.
//   - div_state_e   : divider control states (IDLE, CALC, FIX, DONE)
//   - DEFAULT_WIDTH : default operand width (even, >= 4)
//   - abs_mag()     : two's-complement magnitude of a sign-extended operand
//   - neg()         : two's-complement negate
// The helpers work on a wide container; callers sign/zero-extend into it and
// truncate the result back to their own width, which is exact because
// two's-complement negation is arithmetic modulo 2^n.
// -----------------------------------------------------------------------------
package arith_pkg;

    localparam int DEFAULT_WIDTH = 12;
    localparam int MAX_W         = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Input must be sign-extended; |-2^(W-1)| = 2^(W-1) still fits W unsigned bits.
    function automatic logic [MAX_W-1:0] abs_mag(input logic signed [MAX_W-1:0] x);
        logic [MAX_W-1:0] m;
        if (x[MAX_W-1]) begin
            m = -x;
        end else begin
            m = x;
        end
        return m;
    endfunction

    function automatic logic [MAX_W-1:0] neg(input logic [MAX_W-1:0] x);
        return -x;
    endfunction

endpackage

// File: rtl/seq_booth_divider_if.sv
// -----------------------------------------------------------------------------
// seq_booth_divider_if
// Start/done handshake and operand/result bundle of the sequential divider.
//   start       : request, sampled only while the divider is idle
//   dividend    : signed numerator   (WIDTH)
//   divisor     : signed denominator (WIDTH)
//   busy        : operation in progress
//   done        : one-cycle pulse, results valid from this cycle on
//   quotient    : signed quotient    (WIDTH)
//   remainder   : signed remainder   (WIDTH)
//   div_by_zero : divisor was zero
//   overflow    : -2^(WIDTH-1) / -1
// Modports: master (requester side), slave (divider side).
// -----------------------------------------------------------------------------
interface seq_booth_divider_if #(
    parameter int WIDTH = arith_pkg::DEFAULT_WIDTH
);
    logic                    start;
    logic signed [WIDTH-1:0] dividend;
    logic signed [WIDTH-1:0] divisor;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] quotient;
    logic signed [WIDTH-1:0] remainder;
    logic                    div_by_zero;
    logic                    overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_booth_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on the partial remainder {R,Q}:
// shift left by one, trial-subtract the divisor magnitude, keep the difference
// when it is non-negative and shift the outcome into the Q LSB.
// Ports:
//   r_i : partial remainder R (WIDTH, unsigned, always < d_i)
//   q_i : dividend bits still to consume / quotient bits produced (WIDTH)
//   d_i : divisor magnitude (WIDTH, unsigned)
//   r_o : next R
//   q_o : next Q
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = arith_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] trial;
    logic           fits;

    // R < d <= 2^(WIDTH-1), so the shifted value stays below 2^WIDTH and the
    // extra MSB of the difference is a clean borrow flag.
    assign r_sh  = {r_i, q_i[WIDTH-1]};
    assign trial = r_sh - {1'b0, d_i};
    assign fits  = ~trial[WIDTH];

    assign r_o = fits ? trial[WIDTH-1:0] : r_sh[WIDTH-1:0];
    assign q_o = {q_i[WIDTH-2:0], fits};
endmodule

// File: rtl/seq_booth_divider.sv
// -----------------------------------------------------------------------------
// seq_booth_divider
// Sequential signed two's-complement divider (truncation toward zero), the
// inverse of the combinational radix-4 Booth multiplier. Magnitude-based
// restoring algorithm with fixed, data-independent latency.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : seq_booth_divider_if.slave (start/operands in, busy/done/results out)
// Parameter WIDTH: operand width, must be even and >= 4.
// Build option: define DIV_RADIX4_EN to retire two restoring steps per CALC
// cycle (ITER = WIDTH/2) instead of one (ITER = WIDTH). Results and flags are
// identical in both builds; only the latency changes (ITER+2 edges from the
// accepting edge to done).
// -----------------------------------------------------------------------------
module seq_booth_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    seq_booth_divider_if.slave bus
);

`ifdef DIV_RADIX4_EN
    localparam int ITER = WIDTH / 2;
`else
    localparam int ITER = WIDTH;
`endif
    localparam int               CNT_W   = $clog2(ITER + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dzf_q, dzf_d;
    logic             ovff_q, ovff_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] r_step, q_step;
    logic [WIDTH-1:0] q_signed, r_signed;

    // Restoring step(s) retired per CALC cycle.
`ifdef DIV_RADIX4_EN
    logic [WIDTH-1:0] r_mid, q_mid;

    div_step #(.WIDTH(WIDTH)) u_step0 (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (dmag_q),
        .r_o (r_mid),
        .q_o (q_mid)
    );

    div_step #(.WIDTH(WIDTH)) u_step1 (
        .r_i (r_mid),
        .q_i (q_mid),
        .d_i (dmag_q),
        .r_o (r_step),
        .q_o (q_step)
    );
`else
    div_step #(.WIDTH(WIDTH)) u_step0 (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (dmag_q),
        .r_o (r_step),
        .q_o (q_step)
    );
`endif

    // Quotient is negative when operand signs differ; remainder follows the
    // dividend's sign. The -2^(W-1)/-1 case needs no special arithmetic: the
    // magnitude 2^(W-1) is left un-negated and already reads as -2^(W-1).
    assign q_signed = (dvd_neg_q ^ dvs_neg_q) ? WIDTH'(neg(MAX_W'(q_q))) : q_q;
    assign r_signed = dvd_neg_q ? WIDTH'(neg(MAX_W'(r_q))) : r_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = CALC;
            CALC: if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        cnt_d     = cnt_q;
        r_d       = r_q;
        q_d       = q_q;
        dmag_d    = dmag_q;
        dvd_d     = dvd_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dzf_d     = dzf_q;
        ovff_d    = ovff_q;
        // busy covers CALC and FIX; done is a registered pulse that lands in
        // the cycle after DONE, i.e. the first IDLE cycle.
        busy_d    = (state_d == CALC) || (state_d == FIX);
        done_d    = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_d     = bus.dividend;
                    dvd_neg_d = bus.dividend[WIDTH-1];
                    dvs_neg_d = bus.divisor[WIDTH-1];
                    q_d       = WIDTH'(abs_mag(MAX_W'(bus.dividend)));
                    dmag_d    = WIDTH'(abs_mag(MAX_W'(bus.divisor)));
                    r_d       = '0;
                    dz_d      = (bus.divisor == '0);
                    ovf_d     = (bus.dividend == MIN_VAL) && (bus.divisor == '1);
                    cnt_d     = CNT_W'(ITER);
                    dzf_d     = 1'b0;
                    ovff_d    = 1'b0;
                end
            end
            CALC: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q - CNT_W'(1);
            end
            FIX: begin
                if (dz_q) begin
                    quot_d = '1;
                    rem_d  = dvd_q;
                    dzf_d  = 1'b1;
                end else if (ovf_q) begin
                    quot_d = MIN_VAL;
                    rem_d  = '0;
                    ovff_d = 1'b1;
                end else begin
                    quot_d = q_signed;
                    rem_d  = r_signed;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            r_q       <= '0;
            q_q       <= '0;
            dmag_q    <= '0;
            dvd_q     <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dzf_q     <= 1'b0;
            ovff_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            q_q       <= q_d;
            dmag_q    <= dmag_d;
            dvd_q     <= dvd_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dzf_q     <= dzf_d;
            ovff_q    <= ovff_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dzf_q;
    assign bus.overflow    = ovff_q;

endmodule
